// File: rtl/uart_loader.sv
// uart_loader: parses a framed program image arriving as UART bytes
// (16-bit little-endian word count, little-endian 32-bit words, 8-bit
// additive checksum) and writes the words into instruction memory from
// word address 0 upward, holding the CPU stalled while the load runs.
//
// Handshake: a byte is taken only on the rising edge of rx_done_tick while
// load_en is high; rx_out is sampled in that same cycle. There is no
// back-pressure toward the receiver. mem_we is a one-cycle strobe and
// mem_addr/mem_wdata are valid in that cycle (they hold otherwise).
module uart_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024,
    parameter int TIMEOUT   = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic              rx_done_tick,
    input  logic [7:0]        rx_out,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LEN_HI, DATA, CSUM} state_t;

    state_t            state, state_next;
    logic              prev_tick;
    logic [7:0]        len_lo;
    logic [15:0]       len_n;
    logic [15:0]       word_idx;
    logic [1:0]        byte_idx;
    logic [23:0]       word_buf;
    logic [7:0]        sum;
    logic [TW-1:0]     tcnt;

    // Next values of the registered outputs
    logic              we_d, done_d, hold_d, err_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_d;

    logic              accept;
    logic [15:0]       len_full;
    logic              len_bad;
    logic              last_byte;
    logic              last_word;
    logic              timeout_hit;

    assign accept      = rx_done_tick && !prev_tick && load_en;
    assign len_full    = {rx_out, len_lo};
    assign len_bad     = (len_full == 16'd0) || (32'(len_full) > MAX_WORDS);
    assign last_byte   = (byte_idx == 2'd3);
    assign last_word   = (word_idx == len_n - 16'd1);
    // An accepted byte in the expiry cycle wins over the timeout.
    assign timeout_hit = (state != IDLE) && !accept && (tcnt == TW'(TIMEOUT - 1));

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        if (timeout_hit) begin
            state_next = IDLE;
        end else if (accept) begin
            case (state)
                IDLE:    state_next = LEN_HI;
                LEN_HI:  state_next = len_bad ? IDLE : DATA;
                DATA:    state_next = (last_byte && last_word) ? CSUM : DATA;
                CSUM:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM output logic: next values for the registered outputs
    always_comb begin
        we_d    = 1'b0;
        done_d  = 1'b0;
        hold_d  = cpu_hold;
        err_d   = load_err;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        if (timeout_hit) begin
            err_d  = 1'b1;
            hold_d = 1'b0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    err_d  = 1'b0;
                    hold_d = 1'b1;
                end
                LEN_HI: begin
                    if (len_bad) begin
                        err_d  = 1'b1;
                        hold_d = 1'b0;
                    end
                end
                DATA: begin
                    if (last_byte) begin
                        we_d    = 1'b1;
                        addr_d  = word_idx[ADDR_W-1:0];
                        wdata_d = {rx_out, word_buf};
                    end
                end
                CSUM: begin
                    hold_d = 1'b0;
                    if (rx_out == sum) done_d = 1'b1;
                    else               err_d  = 1'b1;
                end
                default: begin
                    hold_d = 1'b0;
                end
            endcase
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            cpu_hold  <= hold_d;
            load_done <= done_d;
            load_err  <= err_d;
        end
    end

    // Datapath: edge detect, inactivity counter, length, word assembly, checksum
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_tick <= 1'b0;
            tcnt      <= '0;
            len_lo    <= '0;
            len_n     <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
            sum       <= '0;
        end else begin
            prev_tick <= rx_done_tick;
            if (state == IDLE || accept || timeout_hit) tcnt <= '0;
            else                                        tcnt <= tcnt + 1'b1;
            if (accept && !timeout_hit) begin
                case (state)
                    IDLE: begin
                        len_lo   <= rx_out;
                        word_idx <= '0;
                        sum      <= '0;
                    end
                    LEN_HI: begin
                        len_n    <= len_full;
                        byte_idx <= '0;
                    end
                    DATA: begin
                        sum      <= sum + rx_out;
                        byte_idx <= byte_idx + 2'd1;
                        word_buf <= {rx_out, word_buf[23:8]};
                        if (last_byte) word_idx <= word_idx + 16'd1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Downstream consumer of the UART receiver. Takes received bytes (rx_done_tick / rx_out) and parses a framed program image: 16-bit word count, little-endian 32-bit words, 8-bit checksum.
- Writes each assembled word into instruction memory starting at word address 0.
- Holds the CPU stalled for the whole load and reports done or error.

Parameters:
- ADDR_W, 10, width of the instruction-memory word address.
- MAX_WORDS, 1024, largest accepted word count (must be ≤ 2^ADDR_W).
- TIMEOUT, 100000, clk cycles allowed between accepted bytes before the load is aborted.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset: reset=0 resets the block immediately.
- load_en  in  1  when 0, all incoming bytes are ignored.
- rx_done_tick  in  1  byte-valid strobe from uart_rx.
- rx_out  in  8  received byte from uart_rx.
- mem_we  out  1  one-cycle instruction-memory write strobe.
- mem_addr  out  ADDR_W  word address for the write.
- mem_wdata  out  32  word to write.
- cpu_hold  out  1  high while a load is in progress.
- load_done  out  1  one-cycle pulse on a successful load.
- load_err  out  1  sticky error flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs are 0.
  - State is IDLE; all counters, the checksum accumulator and the edge-detect register are 0.
- Byte acceptance:
  - A byte is accepted in cycle t when rx_done_tick=1 in t, rx_done_tick=0 in t-1, and load_en=1.
  - rx_out is sampled in that same cycle t.
  - A strobe held high for several cycles yields exactly one byte.
- States: IDLE, LEN_HI, DATA, CSUM.
- IDLE:
  - An accepted byte becomes the count low byte.
  - Same cycle: load_err clears, word address clears to 0, sum clears to 0.
  - Next cycle: cpu_hold=1; go to LEN_HI.
- LEN_HI:
  - An accepted byte becomes the count high byte, giving N = {hi, lo}.
  - If N==0 or N>MAX_WORDS: go to IDLE; next cycle load_err=1 and cpu_hold=0.
  - Otherwise go to DATA with byte index 0.
- DATA:
  - Bytes arrive b0..b3 per word; each is added to an 8-bit sum, modulo 256.
  - In the cycle after b3 is accepted: mem_we=1, mem_wdata={b3,b2,b1,b0}, mem_addr=current word index. The word index then increments.
  - After word N-1 is written, go to CSUM.
  - mem_addr and mem_wdata hold their last values when mem_we=0.
- CSUM:
  - On an accepted byte equal to the sum: next cycle load_done=1 for one cycle, cpu_hold=0, go to IDLE.
  - On a byte not equal to the sum: next cycle load_err=1, cpu_hold=0, go to IDLE.
  - Words already written are not rolled back.
- Count bytes are not included in the checksum.
- Timeout:
  - In any state other than IDLE, a counter increments each cycle and clears on every accepted byte.
  - When the counter reaches TIMEOUT-1: go to IDLE, set load_err=1, drop cpu_hold.
  - A partially assembled word is discarded and never written.
- load_en dropping mid-load only suppresses byte acceptance; the timeout still runs.
- Simultaneous events: a byte accepted in the same cycle the timeout would expire takes priority and clears the counter.
- load_err stays set until the next load begins or reset.
- Reset mid-load aborts with no further writes. The next load starts at address 0.

Test Plan:
- Bytes 01 00 EF BE AD DE 38 → one mem_we pulse with addr=0, data=0xDEADBEEF; then load_done pulse, load_err=0; cpu_hold high from the cycle after the first byte until load_done.
- Bytes 02 00 11 22 33 44 55 66 77 88 64 → writes addr0=0x44332211 and addr1=0x88776655; then load_done.
- Bytes 01 00 EF BE AD DE 39 → write to addr0 still occurs; load_err=1, no load_done, cpu_hold=0.
- Count 00 00, and separately count 01 04 (1025 > MAX_WORDS) → load_err=1 right after the second byte, no writes; a following valid load clears load_err and succeeds.
- Bytes 01 00 EF then idle for TIMEOUT cycles → load_err=1, cpu_hold=0, no mem_we. Separately, rx_done_tick held high 3 cycles → exactly one byte accepted.
- Reset pulsed low after 01 00 EF BE → all outputs 0 at once; next load of 01 00 EF BE AD DE 38 writes addr0=0xDEADBEEF.
